sliding_window_gen: RTL



---
 rtl/img_processing_pkg.sv | 22 ++
 rtl/line_buffer.sv | 26 ++
 rtl/sliding_window_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/img_processing_pkg.sv
// Shared image-pipeline types and constants: frame geometry, stream widths,
// the 3x3 window type and the window generator state encoding.
package img_processing_pkg;

  localparam int IMG_W            = 640;
  localparam int IMG_H            = 480;
  localparam int KERNEL_SIZE      = 3;
  localparam int AXIS_TDATA_WIDTH = 8;
  localparam int WIN_TDATA_WIDTH  = KERNEL_SIZE * KERNEL_SIZE * AXIS_TDATA_WIDTH;

  // Indexed [row][col]; element [r][c] sits at byte 3*r+c of the flattened bus.
  typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][AXIS_TDATA_WIDTH-1:0] window_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    EOLF  = 3'd3,
    DRAIN = 3'd4
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port line memory: combinational read and clocked write at the same
// address, so a read in the write cycle returns the old contents.
module line_buffer #(
  parameter int DEPTH = img_processing_pkg::IMG_W,
  parameter int WIDTH = 2 * img_processing_pkg::AXIS_TDATA_WIDTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Write port; contents need no reset because stale rows are padded away.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sliding_window_gen.sv
// 3x3 sliding window generator: raster pixels in, one zero-padded neighbourhood
// per pixel out, with self-generated end-of-line and end-of-frame flush beats.
module sliding_window_gen #(
  parameter int IMG_W       = img_processing_pkg::IMG_W,
  parameter int IMG_H       = img_processing_pkg::IMG_H,
  parameter int KERNEL_SIZE = 3,
  parameter int DW          = img_processing_pkg::AXIS_TDATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tuser,
  input  logic            s_axis_tlast,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [9*DW-1:0] m_axis_tdata,
  output logic            m_axis_tuser,
  output logic            m_axis_tlast,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready
);
  import img_processing_pkg::*;

  if (KERNEL_SIZE != 3) begin : g_bad_kernel
    $error("sliding_window_gen: only KERNEL_SIZE = 3 is supported");
  end
  if (DW != AXIS_TDATA_WIDTH) begin : g_bad_dw
    $error("sliding_window_gen: DW must equal AXIS_TDATA_WIDTH");
  end

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0]     COL_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]     COL_ONE   = CW'(1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_ZERO  = {RW{1'b0}};
  localparam logic [RW-1:0]     ROW_ONE   = RW'(1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0]     ROW_DRAIN = RW'(IMG_H);
  localparam logic [DW-1:0]     PIX_ZERO  = {DW{1'b0}};
  localparam logic [3*DW-1:0]   VEC_ZERO  = {(3*DW){1'b0}};
  localparam window_t           WIN_ZERO  = {WIN_TDATA_WIDTH{1'b0}};

  win_state_t           state_r, state_nxt_s;
  logic [CW-1:0]        col_r, col_nxt_s, ecol_s;
  logic [RW-1:0]        row_r, row_nxt_s, erow_s;
  logic                 adv_s, flush_beat_s, pix_beat_s, start_s;
  logic                 beat_s, emit_s, lb_en_s, pad_top_s, pad_left_s;
  logic [DW-1:0]        pix_s;
  logic [2*DW-1:0]      lb_rdata_s, lb_wdata_s;
  logic [2:0][DW-1:0]   vec_s;
  window_t              win_r, win_base_s, win_nxt_s, out_s;
  logic                 s_tlast_unused_s;

  // Column counter is authoritative for line boundaries.
  assign s_tlast_unused_s = s_axis_tlast;

  // lb1 in the upper half, lb0 in the lower half; both shift down one row per write.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(2*DW)) u_lb (
    .clk   (clk),
    .en    (lb_en_s),
    .addr  (ecol_s),
    .wdata (lb_wdata_s),
    .rdata (lb_rdata_s)
  );

  // Beat decode, next-state/counter sequencing and column-vector selection.
  always_comb begin
    adv_s         = !m_axis_tvalid || m_axis_tready;
    flush_beat_s  = adv_s && ((state_r == EOLF) || (state_r == DRAIN));
    s_axis_tready = !rst && adv_s && !flush_beat_s &&
                    ((state_r == IDLE) || (state_r == FILL) || (state_r == RUN));
    pix_beat_s    = s_axis_tvalid && s_axis_tready;
    start_s       = pix_beat_s && s_axis_tuser;
    ecol_s        = start_s ? COL_ZERO : col_r;
    erow_s        = start_s ? ROW_ZERO : row_r;
    pix_s         = pix_beat_s ? s_axis_tdata : PIX_ZERO;
    lb_wdata_s    = {lb_rdata_s[DW-1:0], pix_s};
    state_nxt_s   = state_r;
    col_nxt_s     = col_r;
    row_nxt_s     = row_r;
    lb_en_s       = 1'b0;
    beat_s        = 1'b0;
    emit_s        = 1'b0;
    vec_s         = VEC_ZERO;
    case (state_r)
      IDLE, FILL, RUN: begin
        if (pix_beat_s && (start_s || (state_r != IDLE))) begin
          lb_en_s   = 1'b1;
          beat_s    = 1'b1;
          vec_s     = {pix_s, lb_rdata_s[DW-1:0], lb_rdata_s[2*DW-1:DW]};
          emit_s    = (erow_s != ROW_ZERO) && (ecol_s != COL_ZERO);
          row_nxt_s = erow_s;
          if (ecol_s == COL_LAST) begin
            state_nxt_s = EOLF;
            col_nxt_s   = ecol_s;
          end else begin
            state_nxt_s = start_s ? FILL : state_r;
            col_nxt_s   = ecol_s + COL_ONE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      EOLF: begin
        if (flush_beat_s) begin
          beat_s    = 1'b1;
          emit_s    = (row_r != ROW_ZERO);
          col_nxt_s = COL_ZERO;
          if (row_r == ROW_DRAIN) begin
            state_nxt_s = IDLE;
            row_nxt_s   = ROW_ZERO;
          end else if (row_r == ROW_LAST) begin
            state_nxt_s = DRAIN;
            row_nxt_s   = row_r + ROW_ONE;
          end else begin
            state_nxt_s = RUN;
            row_nxt_s   = row_r + ROW_ONE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      DRAIN: begin
        if (flush_beat_s) begin
          beat_s = 1'b1;
          vec_s  = {PIX_ZERO, lb_rdata_s[DW-1:0], lb_rdata_s[2*DW-1:DW]};
          emit_s = (col_r != COL_ZERO);
          if (col_r == COL_LAST) begin
            state_nxt_s = EOLF;
          end else begin
            col_nxt_s = col_r + COL_ONE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        col_nxt_s   = COL_ZERO;
        row_nxt_s   = ROW_ZERO;
      end
    endcase
  end

  // Shift the new column in; a new frame start discards the old columns.
  always_comb begin
    win_base_s = start_s ? WIN_ZERO : win_r;
    pad_top_s  = (erow_s == ROW_ONE);
    pad_left_s = (ecol_s == COL_ONE) && (state_r != EOLF);
    for (int r = 0; r < 3; r++) begin
      win_nxt_s[r][0] = win_base_s[r][1];
      win_nxt_s[r][1] = win_base_s[r][2];
      win_nxt_s[r][2] = vec_s[r];
      for (int c = 0; c < 3; c++) begin
        out_s[r][c] = (((r == 0) && pad_top_s) || ((c == 0) && pad_left_s)) ?
                      PIX_ZERO : win_nxt_s[r][c];
      end
    end
  end

  // State, counters, window columns and the registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      col_r         <= COL_ZERO;
      row_r         <= ROW_ZERO;
      win_r         <= WIN_ZERO;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= {(9*DW){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      col_r   <= col_nxt_s;
      row_r   <= row_nxt_s;
      if (beat_s) begin
        win_r <= win_nxt_s;
      end
      if (adv_s) begin
        m_axis_tvalid <= emit_s;
        if (emit_s) begin
          m_axis_tdata <= out_s;
          m_axis_tuser <= pad_top_s && pad_left_s;
          m_axis_tlast <= (state_r == EOLF);
        end
      end
    end
  end

endmodule
